// File: rtl/counter_gen_pkg.sv
// Shared types for counter_gen: counting modes and direction encoding.
package counter_gen_pkg;

  typedef enum logic [1:0] {
    CNT_UP     = 2'b00,
    CNT_DOWN   = 2'b01,
    CNT_UPDOWN = 2'b10,
    CNT_HOLD   = 2'b11
  } cnt_mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_gen_if.sv
// Control/status bundle of counter_gen. master = controller side, slave = counter side.
interface counter_gen_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) ();
  import counter_gen_pkg::*;

  // No handshake: every control input is a level sampled on each rising edge,
  // and every status output is valid continuously (cmp_match combinationally).
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  cnt_mode_e             mode;
  logic                  sat;
  logic [WIDTH-1:0]      max_val;
  logic [WIDTH-1:0]      cmp_val;
  logic [PRESCALE_W-1:0] presc_div;
  logic [WIDTH-1:0]      counter_out;
  logic                  dir;
  logic                  tc;
  logic                  cmp_match;

  modport master (
    output en, clr, load, load_val, mode, sat, max_val, cmp_val, presc_div,
    input  counter_out, dir, tc, cmp_match
  );

  modport slave (
    input  en, clr, load, load_val, mode, sat, max_val, cmp_val, presc_div,
    output counter_out, dir, tc, cmp_match
  );

endinterface

// File: rtl/counter_gen_prescaler.sv
// Enable-gated clock-step prescaler: tick once every presc_div+1 enabled cycles.
module counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic [PRESCALE_W-1:0] presc_div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick = (cnt_q == presc_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (sync_clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/counter_gen.sv
// Multi-mode counter: up/down/up-down, wrap or saturate, load/clear, compare and terminal count.
// Optional prescaler compiled in with COUNTER_GEN_PRESCALER_EN.
module counter_gen
  import counter_gen_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RESET_VAL  = 0,
  parameter int PRESCALE_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  counter_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             step;
  logic [WIDTH-1:0] max_v;

  assign max_v = bus.max_val;

`ifdef COUNTER_GEN_PRESCALER_EN
  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.en),
    .sync_clr  (bus.clr | bus.load),
    .presc_div (bus.presc_div),
    .tick      (tick)
  );
`else
  logic unused_presc_div;
  assign unused_presc_div = ^bus.presc_div;
  assign tick = 1'b1;
`endif

  assign step = bus.en & tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_V;
      dir_q <= DIR_UP;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
    end
  end

  // dir_q is the up-down FSM state; the fixed modes force it on each step.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (bus.clr) begin
      cnt_d = RST_V;
      dir_d = DIR_UP;
    end else if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (step) begin
      case (bus.mode)
        CNT_UP: begin
          dir_d = DIR_UP;
          if (cnt_q >= max_v) begin
            tc_d  = 1'b1;
            cnt_d = bus.sat ? cnt_q : '0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        CNT_DOWN: begin
          dir_d = DIR_DOWN;
          if (cnt_q == '0) begin
            tc_d  = 1'b1;
            cnt_d = bus.sat ? '0 : max_v;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
        CNT_UPDOWN: begin
          if (dir_q == DIR_UP) begin
            if (cnt_q >= max_v) begin
              tc_d  = 1'b1;
              dir_d = DIR_DOWN;
              cnt_d = (max_v == '0) ? '0 : max_v - WIDTH'(1);
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end else begin
            if (cnt_q == '0) begin
              tc_d  = 1'b1;
              dir_d = DIR_UP;
              cnt_d = (max_v == '0) ? '0 : WIDTH'(1);
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  assign bus.counter_out = cnt_q;
  assign bus.dir         = dir_q;
  assign bus.tc          = tc_q;
  assign bus.cmp_match   = (cnt_q == bus.cmp_val);

endmodule
